// File: rtl/dcache_dm_if.sv
// Bundles the memory-stage request/response and RAM bus signals of dcache_dm.
// slave is the cache's view. master is the pipeline/RAM environment's view.
interface dcache_dm_if #(
    parameter int WORD_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic [WORD_W-1:0] dmemload;
    logic              dhit;
    logic              halt;
    logic              flushed;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic              ramwait;

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, ramload, ramwait,
        output dmemload, dhit, flushed, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, ramload, ramwait,
        input  dmemload, dhit, flushed, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped write-back data cache with one-word lines.
// Misses fetch through a single-outstanding RAM handshake, and halt flushes all dirty lines.
module dcache_dm #(
    parameter int SETS   = 8,
    parameter int WORD_W = 32
) (
    input  logic        CLK,
    input  logic        nRST,
    dcache_dm_if.slave  bus
);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = WORD_W - IDX - 2;
    localparam logic [IDX-1:0] LAST_IDX = IDX'(SETS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_FETCH,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_valid [SETS];
    logic              r_dirty [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS];
    logic [WORD_W-1:0] r_data  [SETS];
    logic [IDX-1:0]    r_fidx;

    logic [IDX-1:0]    w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_req;
    logic              w_hit;
    logic              w_wr_hit;
    logic              w_wb_clr;
    logic              w_fill;
    logic              w_fl_clr;
    logic              w_fl_adv;
    logic              w_unused;

    assign w_idx    = bus.dmemaddr[IDX+1:2];
    assign w_tag    = bus.dmemaddr[WORD_W-1:IDX+2];
    assign w_req    = bus.dmemREN | bus.dmemWEN;
    assign w_hit    = w_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_unused = &{1'b0, bus.dmemaddr[1:0]};

    // NOTE: every output and strobe gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next       = r_state;
        bus.dhit     = 1'b0;
        bus.dmemload = '0;
        bus.flushed  = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        w_wr_hit     = 1'b0;
        w_wb_clr     = 1'b0;
        w_fill       = 1'b0;
        w_fl_clr     = 1'b0;
        w_fl_adv     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.halt) begin
                    w_next = S_FLUSH;
                end else if (w_hit) begin
                    bus.dhit = 1'b1;
                    if (bus.dmemWEN) begin
                        w_wr_hit = 1'b1;
                    end else begin
                        bus.dmemload = r_data[w_idx];
                    end
                end else if (w_req) begin
                    w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = {r_tag[w_idx], w_idx, 2'b00};
                bus.ramstore = r_data[w_idx];
                if (!bus.ramwait) begin
                    w_wb_clr = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_FETCH: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = {bus.dmemaddr[WORD_W-1:2], 2'b00};
                if (!bus.ramwait) begin
                    w_fill = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (r_valid[r_fidx] && r_dirty[r_fidx]) begin
                    bus.ramWEN   = 1'b1;
                    bus.ramaddr  = {r_tag[r_fidx], r_fidx, 2'b00};
                    bus.ramstore = r_data[r_fidx];
                    if (!bus.ramwait) begin
                        w_fl_clr = 1'b1;
                        w_fl_adv = 1'b1;
                    end
                end else begin
                    w_fl_adv = 1'b1;
                end
                if (w_fl_adv && (r_fidx == LAST_IDX)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.flushed = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // NOTE: the line arrays are flops, not RAM macros, so the asynchronous reset can clear every entry at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_fidx  <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= 1'b0;
                r_dirty[s] <= 1'b0;
                r_tag[s]   <= '0;
                r_data[s]  <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_wr_hit) begin
                r_data[w_idx]  <= bus.dmemstore;
                r_dirty[w_idx] <= 1'b1;
            end
            if (w_wb_clr) begin
                r_dirty[w_idx] <= 1'b0;
            end
            // The fill leaves the line clean. A pending write merges on the following hit.
            if (w_fill) begin
                r_data[w_idx]  <= bus.ramload;
                r_tag[w_idx]   <= w_tag;
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end
            if (w_fl_clr) begin
                r_dirty[r_fidx] <= 1'b0;
            end
            if (w_fl_adv) begin
                r_fidx <= r_fidx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm: a RAM model with programmable wait states,
// plus hand-computed expectations for hits, misses, evictions, flush and reset.
module tb_dcache_dm;
    logic clk;
    logic nRST;

    dcache_dm_if #(.WORD_W(32)) bus ();

    dcache_dm #(.SETS(8), .WORD_W(32)) dut (
        .CLK  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // RAM model: every request sees ram_lat busy cycles before it completes.
    logic [31:0] mem [0:255];
    int          ram_lat  = 2;
    int          wait_cnt = 2;
    int          ren_cycles = 0;
    int          wen_cycles = 0;
    int          both_cycles = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    assign bus.ramwait = (bus.ramREN | bus.ramWEN) && (wait_cnt != 0);
    assign bus.ramload = mem[bus.ramaddr[9:2]];

    always @(posedge clk) begin
        if (bus.ramREN) ren_cycles <= ren_cycles + 1;
        if (bus.ramWEN) wen_cycles <= wen_cycles + 1;
        if (bus.ramREN && bus.ramWEN) both_cycles <= both_cycles + 1;
        if (bus.ramREN || bus.ramWEN) begin
            if (wait_cnt != 0) begin
                wait_cnt <= wait_cnt - 1;
            end else begin
                wait_cnt <= ram_lat;
                if (bus.ramWEN) begin
                    mem[bus.ramaddr[9:2]] <= bus.ramstore;
                    wr_addr_q.push_back(bus.ramaddr);
                    wr_data_q.push_back(bus.ramstore);
                end else begin
                    last_rd_addr <= bus.ramaddr;
                end
            end
        end else begin
            wait_cnt <= ram_lat;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Holds a request until dhit (or a cycle budget runs out, returning cyc=0).
    task automatic do_req(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] data, output int cyc, output logic [31:0] load);
        bus.dmemREN   = ren;
        bus.dmemWEN   = wen;
        bus.dmemaddr  = addr;
        bus.dmemstore = data;
        cyc  = 0;
        load = '0;
        for (int n = 1; n <= 64; n++) begin
            #1;
            if (bus.dhit) begin
                cyc  = n;
                load = bus.dmemload;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
    endtask

    int          cyc;
    logic [31:0] load;
    int          ren0;
    int          wen0;
    int          wq0;
    int          dhit_bad;

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;
        mem[8'h10] = 32'hDEADBEEF;   // 0x40
        mem[8'h18] = 32'hCAFEF00D;   // 0x60
        mem[8'h20] = 32'h0BADF00D;   // 0x80
        mem[8'h11] = 32'h11111111;   // 0x44
        mem[8'h13] = 32'h22222222;   // 0x4C
        nRST          = 1'b0;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        bus.halt      = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("reset_dhit",     {31'b0, bus.dhit},    32'd0);
        check("reset_flushed",  {31'b0, bus.flushed}, 32'd0);
        check("reset_ramREN",   {31'b0, bus.ramREN},  32'd0);
        check("reset_ramWEN",   {31'b0, bus.ramWEN},  32'd0);
        check("reset_dmemload", bus.dmemload,         32'd0);
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);

        // Clean read miss: 1 IDLE + 3 FETCH cycles, hit on the 5th.
        ren0 = ren_cycles; wen0 = wen_cycles;
        do_req(1'b1, 1'b0, 32'h40, 32'h0, cyc, load);
        check("rd_miss_cycles", cyc, 32'd5);
        check("rd_miss_data",   load, 32'hDEADBEEF);
        check("rd_miss_ren",    ren_cycles - ren0, 32'd3);
        check("rd_miss_wen",    wen_cycles - wen0, 32'd0);
        check("rd_miss_addr",   last_rd_addr, 32'h40);

        ren0 = ren_cycles;
        do_req(1'b1, 1'b0, 32'h40, 32'h0, cyc, load);
        check("rd_hit_cycles", cyc, 32'd1);
        check("rd_hit_data",   load, 32'hDEADBEEF);
        check("rd_hit_ren",    ren_cycles - ren0, 32'd0);

        wen0 = wen_cycles;
        do_req(1'b0, 1'b1, 32'h40, 32'h12345678, cyc, load);
        check("wr_hit_cycles", cyc, 32'd1);
        check("wr_hit_wen",    wen_cycles - wen0, 32'd0);
        do_req(1'b1, 1'b0, 32'h40, 32'h0, cyc, load);
        check("rd_after_wr",   load, 32'h12345678);

        // Dirty eviction: 1 IDLE + 3 WB + 3 FETCH, hit on the 8th.
        wq0 = wr_addr_q.size();
        do_req(1'b1, 1'b0, 32'h60, 32'h0, cyc, load);
        check("dirty_miss_cycles", cyc, 32'd8);
        check("dirty_miss_data",   load, 32'hCAFEF00D);
        check("dirty_wb_count",    wr_addr_q.size() - wq0, 32'd1);
        check("dirty_wb_addr",     wr_addr_q[wq0], 32'h40);
        check("dirty_wb_data",     wr_data_q[wq0], 32'h12345678);
        check("dirty_fetch_addr",  last_rd_addr, 32'h60);

        wen0 = wen_cycles;
        do_req(1'b1, 1'b0, 32'h80, 32'h0, cyc, load);
        check("clean_evict_cycles", cyc, 32'd5);
        check("clean_evict_data",   load, 32'h0BADF00D);
        check("clean_evict_wen",    wen_cycles - wen0, 32'd0);

        // REN and WEN together behave as a write; it shows up at the next eviction.
        do_req(1'b1, 1'b1, 32'h80, 32'hAAAA5555, cyc, load);
        check("both_hit_cycles", cyc, 32'd1);
        wq0 = wr_addr_q.size();
        do_req(1'b1, 1'b0, 32'h40, 32'h0, cyc, load);
        check("both_evict_cycles", cyc, 32'd8);
        check("both_evict_data",   load, 32'h12345678);
        check("both_wb_count",     wr_addr_q.size() - wq0, 32'd1);
        check("both_wb_addr",      wr_addr_q[wq0], 32'h80);
        check("both_wb_data",      wr_data_q[wq0], 32'hAAAA5555);

        // Write misses allocate then merge on the following hit.
        do_req(1'b0, 1'b1, 32'h44, 32'h33333333, cyc, load);
        check("wr_miss_cycles_44", cyc, 32'd5);
        do_req(1'b0, 1'b1, 32'h4C, 32'h44444444, cyc, load);
        check("wr_miss_cycles_4c", cyc, 32'd5);

        // Flush with a would-be hit pending: halt wins, dirty lines leave in index order.
        ram_lat      = 1;
        wq0          = wr_addr_q.size();
        bus.halt     = 1'b1;
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h40;
        #1;
        check("halt_prio_dhit", {31'b0, bus.dhit}, 32'd0);
        dhit_bad = 0;
        for (int n = 0; n < 200; n++) begin
            if (bus.dhit) dhit_bad++;
            if (bus.flushed) break;
            @(negedge clk);
            #1;
        end
        check("flush_flushed",  {31'b0, bus.flushed}, 32'd1);
        check("flush_dhit",     dhit_bad, 32'd0);
        check("flush_wb_count", wr_addr_q.size() - wq0, 32'd2);
        check("flush_wb0_addr", wr_addr_q[wq0], 32'h44);
        check("flush_wb0_data", wr_data_q[wq0], 32'h33333333);
        check("flush_wb1_addr", wr_addr_q[wq0 + 1], 32'h4C);
        check("flush_wb1_data", wr_data_q[wq0 + 1], 32'h44444444);
        ren0 = ren_cycles; wen0 = wen_cycles;
        repeat (5) @(negedge clk);
        #1;
        check("done_held",     {31'b0, bus.flushed}, 32'd1);
        check("done_dhit",     {31'b0, bus.dhit},    32'd0);
        check("done_ram_idle", (ren_cycles - ren0) + (wen_cycles - wen0), 32'd0);

        // Reset out of DONE, then reset again in the middle of a fill.
        nRST         = 1'b0;
        bus.halt     = 1'b0;
        bus.dmemREN  = 1'b0;
        @(negedge clk);
        nRST = 1'b1;
        #1;
        check("rst_clears_flushed", {31'b0, bus.flushed}, 32'd0);
        ram_lat = 3;
        @(negedge clk);
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h40;
        @(negedge clk);
        #1;
        check("mid_fetch_ren", {31'b0, bus.ramREN}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("rst_drops_ren",  {31'b0, bus.ramREN}, 32'd0);
        check("rst_drops_addr", bus.ramaddr, 32'd0);
        bus.dmemREN = 1'b0;
        @(negedge clk);
        ram_lat = 2;
        nRST    = 1'b1;
        @(negedge clk);
        ren0 = ren_cycles;
        do_req(1'b1, 1'b0, 32'h40, 32'h0, cyc, load);
        check("post_rst_cycles", cyc, 32'd5);
        check("post_rst_ren",    ren_cycles - ren0, 32'd3);
        check("post_rst_data",   load, 32'h12345678);

        check("ren_wen_exclusive", both_cycles, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Direct-mapped, write-back data cache with one-word blocks.
- Acts as the responder to the memory stage: the EX/MEM latch drives dmemREN/dmemWEN and the address/store data, and holds them stable until this block pulses dhit.
- Misses and dirty evictions go to the RAM/bus side through a single-outstanding req/wait handshake.
- On halt, it writes back every dirty line and then asserts flushed.

Parameters:
- SETS, 8: number of lines; power of 2, at least 2. IDX = log2(SETS).
- WORD_W, 32: data and address width.

Ports:
- CLK in 1: clock, rising edge.
- nRST in 1: asynchronous, active-low reset.
- dmemREN in 1: memory-stage read request.
- dmemWEN in 1: memory-stage write request.
- dmemaddr in 32: byte address; bits [1:0] ignored.
- dmemstore in 32: write data.
- dmemload out 32: read data; valid when dhit=1.
- dhit out 1: request serviced this cycle.
- halt in 1: flush request from the pipeline.
- flushed out 1: all dirty lines written back.
- ramREN out 1: RAM read request.
- ramWEN out 1: RAM write request.
- ramaddr out 32: RAM word address; bits [1:0] = 0.
- ramstore out 32: RAM write data.
- ramload in 32: RAM read data; valid when ramwait=0.
- ramwait in 1: RAM busy; a request completes in the first cycle ramREN or ramWEN is high with ramwait=0.

Behaviour:
- Address split: index = dmemaddr[IDX+1:2]; tag = dmemaddr[31:IDX+2].
- Per line: valid, dirty, tag, data.
- Request = dmemREN | dmemWEN. If both are high, the request is a write.
- Reset (async): all valid/dirty/tag/data cleared, state IDLE, flush counter 0. Every output is 0.
- Defaults: all outputs are 0 unless stated below. dmemload is 0 whenever dhit=0.
- IDLE state:
  - halt=1 takes priority over any request: go to FLUSH, dhit=0.
  - Hit (request & valid & tag match): dhit=1 combinationally in the same cycle.
  - Read hit: dmemload = line data.
  - Write hit: line data <= dmemstore and dirty <= 1 at the clock edge. No RAM activity on any hit.
  - Miss with victim valid & dirty: go to WB.
  - Miss otherwise: go to FETCH.
- WB state:
  - ramWEN=1, ramaddr = {victim tag, index, 2'b00}, ramstore = victim data.
  - On ramwait=0: clear dirty, go to FETCH.
- FETCH state:
  - ramREN=1, ramaddr = {dmemaddr[31:2], 2'b00}.
  - On ramwait=0: data <= ramload, tag written, valid=1, dirty=0, go to IDLE.
  - The request then hits in IDLE on the following cycle; a write miss merges on that hit.
  - A fill that has started completes even if the request drops.
- Miss latency: clean miss = (FETCH cycles) + 1; dirty miss adds the WB cycles. dhit is never asserted outside IDLE.
- FLUSH state:
  - Counter i walks 0..SETS-1.
  - Line i valid & dirty: ramWEN=1, ramaddr = {tag_i, i, 2'b00}, ramstore = data_i. On ramwait=0, clear dirty and i++.
  - Clean or invalid line: i++ in one cycle with no RAM access.
  - After i = SETS-1 completes, go to DONE.
- DONE state: flushed=1, dhit=0, no RAM activity. Held until reset; halt is ignored.
- Write-backs in FLUSH occur strictly in ascending index order.
- ramREN and ramWEN are never high in the same cycle. Each is held constant, with a constant address, until ramwait=0.
- Reset asserted mid-WB, mid-FETCH or mid-FLUSH: RAM requests drop immediately and all lines become invalid. Dirty data is lost by design.
- The requester must hold dmemaddr and dmemstore stable from request until dhit. The verification bench checks the cache only under this protocol.

Test Plan:
- Reset, then read 0x40; RAM holds 2 wait cycles, returns 0xDEADBEEF -> ramREN=1, ramaddr=0x40 for 3 cycles; dhit=1, dmemload=0xDEADBEEF the next cycle. A repeat read of 0x40 hits in 1 cycle with ramREN=ramWEN=0.
- Write 0x12345678 to 0x40 (hit) -> dhit=1 the same cycle, no ramWEN. A read of 0x40 then returns 0x12345678.
- Read 0x60 (same index 0, dirty victim) -> ramWEN with addr 0x40 / data 0x12345678, then ramREN addr 0x60, then dhit with the RAM value.
- Read 0x80 over a clean line at index 0 -> no ramWEN, FETCH directly. Also: REN and WEN both high -> treated as a write (line dirty, later written back).
- Dirty lines at 0x44 and 0x4C, then assert halt -> exactly two ramWEN transactions, 0x44 then 0x4C. flushed=1 afterward and held; dhit=0 throughout.
- nRST pulsed low during FETCH -> ramREN=0 asynchronously. A subsequent read of a previously cached address misses.
